lfsr_stream: RTL and testbench



---
 rtl/lfsr_stream.sv | 103 ++++++++++
 tb/tb_lfsr_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream.sv
// XNOR-feedback Fibonacci LFSR that emits STEP bits per advance on a valid/ready port,
// with seed loading and all-ones lockup protection. Define LFSR_PERIOD_EN for PERIOD_CNT/WRAP.
module lfsr_stream #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8,
    parameter int              STEP  = 1,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             E,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED,
    output logic [STEP-1:0]  OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] STATE,
`ifdef LFSR_PERIOD_EN
    output logic [WIDTH:0]   PERIOD_CNT,
    output logic             WRAP,
`endif
    output logic             LOCKUP
);

    logic [WIDTH-1:0] state_q;
    logic [STEP-1:0]  data_q;
    logic             valid_q;
    logic             lockup_q;

    logic [WIDTH-1:0] nxt_state;
    logic [STEP-1:0]  nxt_data;
    logic             advance;
    logic             seed_illegal;
    logic [WIDTH-1:0] load_state;

    // Handshake: a word transfers on a rising edge where OUT_VALID && OUT_READY.
    // OUT_VALID never drops without a transfer except on RESET/LOAD, and OUT_DATA
    // is frozen while OUT_VALID && !OUT_READY.
    assign advance      = E && (!valid_q || OUT_READY);
    assign seed_illegal = (SEED == {WIDTH{1'b1}});
    assign load_state   = seed_illegal ? INIT : SEED;

    // STEP single steps unrolled; state_q[WIDTH-1] is stage S[WIDTH].
    always_comb begin
        nxt_state = state_q;
        nxt_data  = '0;
        for (int k = 0; k < STEP; k++) begin
            nxt_data[STEP-1-k] = nxt_state[WIDTH-1];
            nxt_state          = {nxt_state[WIDTH-2:0], ~^(nxt_state & TAPS)};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= INIT;
            data_q   <= '0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
        end else if (LOAD) begin
            state_q  <= load_state;
            valid_q  <= 1'b0;
            lockup_q <= seed_illegal;
        end else if (advance) begin
            state_q  <= nxt_state;
            data_q   <= nxt_data;
            valid_q  <= 1'b1;
        end else if (valid_q && OUT_READY) begin
            valid_q  <= 1'b0;
        end
    end

    assign OUT_DATA  = data_q;
    assign OUT_VALID = valid_q;
    assign STATE     = state_q;
    assign LOCKUP    = lockup_q;

`ifdef LFSR_PERIOD_EN
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH:0]   cnt_q;
    logic             wrap_q;

    // ref_q remembers where the sequence started so a full cycle can be flagged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ref_q  <= INIT;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (LOAD) begin
            ref_q  <= load_state;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= advance && (nxt_state == ref_q);
            if (advance && (cnt_q != {(WIDTH+1){1'b1}}))
                cnt_q <= cnt_q + {{WIDTH{1'b0}}, 1'b1};
        end
    end

    assign PERIOD_CNT = cnt_q;
    assign WRAP       = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: directed WIDTH=3 and serial checks, then a scoreboarded
// STEP=8 stream under random enable, backpressure, loads and resets.
module tb_lfsr_stream;

    localparam logic [7:0] TAPS8 = 8'hB8;
    localparam logic [7:0] INIT8 = 8'h00;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed instances (WIDTH=3 and serial WIDTH=8) share these inputs.
    logic       d_reset = 1'b0, d_load = 1'b0, d_e = 1'b0, d_ready = 1'b0;
    logic [7:0] d_seed  = 8'h00;

    logic [2:0] w3_state;
    logic [0:0] w3_data;
    logic       w3_valid, w3_lock;

    lfsr_stream #(.WIDTH(3), .TAPS(3'b110), .STEP(1), .INIT(3'b000)) u_w3 (
        .CLK(CLK), .RESET(d_reset), .E(d_e), .LOAD(d_load), .SEED(d_seed[2:0]),
        .OUT_DATA(w3_data), .OUT_VALID(w3_valid), .OUT_READY(d_ready),
        .STATE(w3_state),
`ifdef LFSR_PERIOD_EN
        .PERIOD_CNT(), .WRAP(),
`endif
        .LOCKUP(w3_lock)
    );

    logic [7:0] s_state;
    logic [0:0] s_data;
    logic       s_valid, s_lock;
`ifdef LFSR_PERIOD_EN
    logic [8:0] s_cnt;
    logic       s_wrap;
`endif

    lfsr_stream #(.WIDTH(8), .TAPS(TAPS8), .STEP(1), .INIT(INIT8)) u_ser (
        .CLK(CLK), .RESET(d_reset), .E(d_e), .LOAD(d_load), .SEED(d_seed),
        .OUT_DATA(s_data), .OUT_VALID(s_valid), .OUT_READY(d_ready),
        .STATE(s_state),
`ifdef LFSR_PERIOD_EN
        .PERIOD_CNT(s_cnt), .WRAP(s_wrap),
`endif
        .LOCKUP(s_lock)
    );

    // Main scoreboarded instance.
    logic       m_reset = 1'b0, m_load = 1'b0, m_e = 1'b0, m_ready = 1'b0;
    logic [7:0] m_seed  = 8'h00;
    logic [7:0] m_data, m_state;
    logic       m_valid, m_lock;

    lfsr_stream #(.WIDTH(8), .TAPS(TAPS8), .STEP(8), .INIT(INIT8)) u_dut (
        .CLK(CLK), .RESET(m_reset), .E(m_e), .LOAD(m_load), .SEED(m_seed),
        .OUT_DATA(m_data), .OUT_VALID(m_valid), .OUT_READY(m_ready),
        .STATE(m_state),
`ifdef LFSR_PERIOD_EN
        .PERIOD_CNT(), .WRAP(),
`endif
        .LOCKUP(m_lock)
    );

    // Reference model: one serial step from the polynomial definition.
    function automatic logic [7:0] ref_step(input logic [7:0] s);
        int  ones;
        logic fb;
        ones = $countones(s & TAPS8);
        fb   = ((ones % 2) == 0);
        return {s[6:0], fb};
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] md_state = INIT8;
    logic       md_valid = 1'b0;
    logic       md_lock  = 1'b0;

    // Monitor: a word leaves the DUT when it is valid and accepted without a flush.
    always @(negedge CLK) begin
        if (m_valid === 1'b1 && m_ready && !m_reset && !m_load) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_data: got %0h expected none (queue empty) at %0t", m_data, $time);
            end else begin
                chk("out_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic r, input logic l, input logic [7:0] sd,
                         input logic e, input logic rdy);
        logic [7:0] w;
        m_reset = r; m_load = l; m_seed = sd; m_e = e; m_ready = rdy;
        if (r) begin
            md_state = INIT8; md_valid = 1'b0; md_lock = 1'b0;
            exp_q.delete();
        end else if (l) begin
            md_lock  = (sd == 8'hFF);
            md_state = md_lock ? INIT8 : sd;
            md_valid = 1'b0;
            exp_q.delete();
        end else if (e && (!md_valid || rdy)) begin
            w = '0;
            for (int k = 0; k < 8; k++) begin
                w        = {w[6:0], md_state[7]};
                md_state = ref_step(md_state);
            end
            exp_q.push_back(w);
            md_valid = 1'b1;
        end else if (md_valid && rdy) begin
            md_valid = 1'b0;
        end
        @(posedge CLK); #1;
        chk("state", m_state, md_state);
        chk("out_valid", m_valid, md_valid);
        chk("lockup", m_lock, md_lock);
    endtask

    logic [2:0] w3_st [7] = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100};
    logic       w3_bit[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [7:0] s;
        logic       bit_e;
        @(posedge CLK); #1;

        // WIDTH=3 known sequence from reset.
        d_reset = 1'b1;
        @(posedge CLK); #1;
        d_reset = 1'b0;
        chk("w3_reset_state", w3_state, 3'b000);
        chk("w3_reset_valid", w3_valid, 1'b0);
        chk("w3_reset_lockup", w3_lock, 1'b0);
        d_e = 1'b1; d_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge CLK); #1;
            chk("w3_state", w3_state, w3_st[(i + 1) % 7]);
            chk("w3_data", w3_data, w3_bit[i % 7]);
            chk("w3_valid", w3_valid, 1'b1);
        end

        // Serial WIDTH=8 stream from seed 01, with full-period wrap.
        d_e = 1'b0; d_load = 1'b1; d_seed = 8'h01;
        @(posedge CLK); #1;
        d_load = 1'b0;
        chk("ser_load_state", s_state, 8'h01);
        chk("ser_load_valid", s_valid, 1'b0);
`ifdef LFSR_PERIOD_EN
        chk("ser_load_cnt", s_cnt, 9'd0);
        chk("ser_load_wrap", s_wrap, 1'b0);
`endif
        s = 8'h01;
        d_e = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge CLK); #1;
            bit_e = s[7];
            s     = ref_step(s);
            chk("ser_data", s_data, bit_e);
            chk("ser_state", s_state, s);
`ifdef LFSR_PERIOD_EN
            chk("ser_wrap", s_wrap, (i == 255));
            chk("ser_cnt", s_cnt, i);
`endif
        end
        d_e = 1'b0;

        // Main instance: reset, 300 full-throughput words from seed 01.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Backpressure then burst.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Illegal seed, then legal seed clears LOCKUP.
        drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        chk("legal_seed_state", m_state, 8'h5A);

        // Reset mid-stream; restart matches post-reset sequence.
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic       r, l, e, rdy;
            logic [7:0] sd;
            r   = ($urandom_range(0, 99) == 0);
            l   = ($urandom_range(0, 39) == 0);
            sd  = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            e   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            drive(r, l, sd, e, rdy);
        end

        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
